// File: rtl/ucaspian_scan_pkg.sv
// Shared types and helpers for activity scan blocks.
// Index type is sized for the widest supported bitfield.
package ucaspian_scan_pkg;

  localparam int MAX_SCAN_WIDTH = 256;

  typedef logic [$clog2(MAX_SCAN_WIDTH)-1:0] scan_idx_t;

  function automatic logic [MAX_SCAN_WIDTH-1:0]
    onehot_clr(input scan_idx_t idx);
    logic [MAX_SCAN_WIDTH-1:0] m;
    m = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/activity_scan_queue_if.sv
// Delivery port of the activity scan queue.
// master drives index/valid, slave returns ready.
interface activity_scan_queue_if #(
  parameter int WIDTH = 16
);

  localparam int IDX_W = $clog2(WIDTH);

  logic             out_vld;
  logic             out_rdy;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output out_vld,
    output out_idx,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_idx,
    output out_rdy
  );

endinterface

// File: rtl/find_first_set.sv
// LSB-first set-bit encoder; idx is 0 when nothing is set.
// ACTIVITY_SCAN_RR_EN: search begins at rr_ptr and wraps.
module find_first_set #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
`ifdef ACTIVITY_SCAN_RR_EN
  input  logic [IDX_W-1:0] rr_ptr,
`endif
  output logic [IDX_W-1:0] idx,
  output logic             none_found
);

  logic [WIDTH-1:0] rot;
  logic [IDX_W-1:0] enc;

`ifdef ACTIVITY_SCAN_RR_EN
  // rotate right so rr_ptr lands at bit 0
  always_comb begin
    rot = '0;
    for (int i = 0; i < WIDTH; i++)
      rot[i] = vec[IDX_W'(i) + rr_ptr];
  end
  assign idx = enc + rr_ptr;
`else
  assign rot = vec;
  assign idx = enc;
`endif

  // lowest set bit of the (rotated) vector
  always_comb begin
    enc = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rot[i]) enc = IDX_W'(i);
  end

  assign none_found = ~|vec;

endmodule

// File: rtl/activity_scan_queue.sv
// Pending-activity bitfield drained one index per transfer.
// ACTIVITY_SCAN_RR_EN selects round-robin over fixed priority.
module activity_scan_queue
  import ucaspian_scan_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               set_vld,
  input  logic [WIDTH-1:0]   set_mask,
  input  logic               flush,
  activity_scan_queue_if.master out_if,
  output logic [WIDTH-1:0]   pending,
  output logic               idle
);

  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_nx;
  logic [WIDTH-1:0] clr_mask;
  logic             out_vld_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W-1:0] sel;
  logic             none;
  logic             load_en;
  logic             take;

`ifdef ACTIVITY_SCAN_RR_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  find_first_set #(.WIDTH(WIDTH)) u_ffs (
    .vec        (pend_q),
`ifdef ACTIVITY_SCAN_RR_EN
    .rr_ptr     (rr_ptr),
`endif
    .idx        (sel),
    .none_found (none)
  );

  assign load_en  = ~out_vld_q | out_if.out_rdy;
  assign take     = load_en & ~none & ~flush;
  assign clr_mask = WIDTH'(onehot_clr(scan_idx_t'(sel)));

  // drop the bit being loaded, then merge new sets
  always_comb begin
    pend_nx = pend_q;
    if (flush)
      pend_nx = '0;
    else if (take)
      pend_nx = pend_q & clr_mask;
    if (set_vld)
      pend_nx = pend_nx | set_mask;
  end

  // pending bitfield register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pend_q <= '0;
    else
      pend_q <= pend_nx;
  end

  // output stage: reload when empty or accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q <= 1'b0;
      out_idx_q <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (load_en) begin
      out_vld_q <= ~none;
      if (!none)
        out_idx_q <= sel;
    end
  end

`ifdef ACTIVITY_SCAN_RR_EN
  // next search starts just past the last loaded index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_ptr <= '0;
    else if (take)
      rr_ptr <= sel + IDX_W'(1);
  end
`endif

  assign out_if.out_vld = out_vld_q;
  assign out_if.out_idx = out_idx_q;
  assign pending        = pend_q;
  assign idle           = ~out_vld_q & ~|pend_q;

endmodule

// File: tb/tb_activity_scan_queue.sv
// Scoreboard bench for activity_scan_queue (WIDTH=16).
// Reference model is a cycle-level set/drain abstraction.
module tb_activity_scan_queue;

  localparam int W = 16;

  typedef struct {
    bit          vld;
    int          idx;
    logic [W-1:0] pend;
    bit          idle;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         set_vld = 1'b0;
  logic [W-1:0] set_mask = '0;
  logic         flush = 1'b0;
  logic [W-1:0] pending;
  logic         idle;

  activity_scan_queue_if #(.WIDTH(W)) oif ();

  activity_scan_queue #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_vld  (set_vld),
    .set_mask (set_mask),
    .flush    (flush),
    .out_if   (oif),
    .pending  (pending),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   acc_log[$];

  bit           m_vld;
  int           m_idx;
  logic [W-1:0] m_pend;
  int           m_ptr;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, req, req);
    end
  endtask

  function automatic int pick(logic [W-1:0] p, int start);
    for (int k = 0; k < W; k++)
      if (p[(start + k) % W]) return (start + k) % W;
    return 0;
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_idx  = 0;
    m_pend = '0;
    m_ptr  = 0;
  endtask

  // push expected state, drive inputs, advance model one cycle
  task automatic cycle(bit sv, logic [W-1:0] sm, bit fl, bit rdy);
    exp_t e;
    int   s;
    e.vld  = m_vld;
    e.idx  = m_idx;
    e.pend = m_pend;
    e.idle = !m_vld && (m_pend == '0);
    exp_q.push_back(e);
    set_vld     = sv;
    set_mask    = sm;
    flush       = fl;
    oif.out_rdy = rdy;
    if (fl) begin
      m_vld  = 0;
      m_pend = '0;
    end else if (!m_vld || rdy) begin
      if (m_pend != '0) begin
`ifdef ACTIVITY_SCAN_RR_EN
        s = pick(m_pend, m_ptr);
        m_ptr = (s + 1) % W;
`else
        s = pick(m_pend, 0);
`endif
        m_idx     = s;
        m_vld     = 1;
        m_pend[s] = 1'b0;
      end else begin
        m_vld = 0;
      end
    end
    if (sv) m_pend = m_pend | sm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 1);
  endtask

  task automatic check_log(string name, int n,
                           int a, int b, int c, int d);
    int r[4];
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    chk({name, "_count"}, acc_log.size(), n);
    for (int i = 0; i < n && i < acc_log.size(); i++)
      chk({name, "_idx"}, acc_log[i], r[i]);
    acc_log.delete();
  endtask

  // monitor: compare DUT against scoreboard every cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_vld", int'(oif.out_vld), int'(e.vld));
      if (e.vld) chk("out_idx", int'(oif.out_idx), e.idx);
      chk("pending", int'(pending), int'(e.pend));
      chk("idle", int'(idle), int'(e.idle));
    end
    if (reset_n && oif.out_vld && oif.out_rdy)
      acc_log.push_back(int'(oif.out_idx));
  end

  initial begin
    logic [W-1:0] seen;
    oif.out_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", int'(oif.out_vld), 0);
    chk("rst_idx", int'(oif.out_idx), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_idle", int'(idle), 1);
    reset_n = 1'b1;

    // reset mid-drain
    cycle(1, 16'hFFFF, 0, 1);
    idle_cycles(3);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(oif.out_vld), 0);
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_idle", int'(idle), 1);
    model_reset();
    exp_q.delete();
    acc_log.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(2);

`ifdef ACTIVITY_SCAN_RR_EN
    cycle(1, 16'h0013, 0, 1);
    idle_cycles(6);
    check_log("rr_first", 3, 0, 1, 4, 0);
    cycle(1, 16'h0013, 0, 1);
    idle_cycles(6);
    check_log("rr_wrap", 3, 0, 1, 4, 0);
`else
    cycle(1, 16'h8421, 0, 1);
    idle_cycles(8);
    check_log("prio", 4, 0, 5, 10, 15);
    chk("prio_idle", int'(idle), 1);

    cycle(1, 16'h0006, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, '0, 0, 0);
    chk("bp_idx", int'(oif.out_idx), 1);
    chk("bp_pending", int'(pending), 16'h0004);
    idle_cycles(5);
    check_log("bp", 2, 1, 2, 0, 0);

    cycle(1, 16'h0008, 0, 1);
    cycle(1, 16'h0008, 0, 1);
    idle_cycles(5);
    check_log("dup", 2, 3, 3, 0, 0);

    cycle(1, 16'h00F0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(1, 16'h00F0, 0, 0);
    chk("fl_pre_pending", int'(pending), 16'h00F0);
    cycle(1, 16'h0001, 1, 1);
    idle_cycles(5);
    check_log("flush", 2, 4, 0, 0, 0);
`endif

    // all-ones drain: each index exactly once
    acc_log.delete();
    cycle(1, 16'hFFFF, 0, 1);
    idle_cycles(W + 4);
    chk("drain_count", acc_log.size(), W);
    seen = '0;
    foreach (acc_log[i]) seen[acc_log[i]] = 1'b1;
    chk("drain_cover", int'(seen), 16'hFFFF);
    acc_log.delete();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 3, W'($urandom),
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) < 6);
    idle_cycles(W + 4);
    chk("final_idle", int'(idle), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
